// File: rtl/jtframe_prom_ctl.sv
// PROM/RAM sequencer. The write side takes the ioctl download stream, keeps
// only the bytes inside this memory's address window, packs them into DW-bit
// words and issues write pulses. The read side shares the single synchronous
// read port between two requesters, A and B, using a round-robin arbiter.
module jtframe_prom_ctl #(
   parameter int DW    = 8,
   parameter int AW    = 10,
   parameter int START = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          downloading,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   input  logic          ioctl_wr,
   output logic          prom_we,
   output logic [AW-1:0] prom_wr_addr,
   output logic [DW-1:0] prom_data,
   output logic [AW-1:0] prom_rd_addr,
   output logic          prom_cen,
   input  logic [DW-1:0] prom_q,
   input  logic          a_req,
   input  logic [AW-1:0] a_addr,
   output logic          a_ok,
   output logic [DW-1:0] a_dout,
   input  logic          b_req,
   input  logic [AW-1:0] b_addr,
   output logic          b_ok,
   output logic [DW-1:0] b_dout,
   output logic          done
);

   localparam int             BYTES    = DW / 8;
   localparam int             SHIFT    = BYTES - 1;
   localparam bit             PACK     = (DW == 16);
   localparam logic [25:0]    WIN_LO   = 26'(START);
   localparam logic [25:0]    WIN_SIZE = 26'((2 ** AW) * BYTES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_FINISH
   } state_t;

   state_t      state;
   logic        rr_b;
   logic        grant_b;
   logic        pick_b;
   logic        dl_d;
   logic        wrote;
   logic [25:0] addr_ext;
   logic [24:0] offset;
   logic        in_win;
   logic        accept;
   logic        wr_hit;

   // The window test is done on the offset so that every offset bit matters,
   // not just the ones that end up forming the word address.
   assign addr_ext = {1'b0, ioctl_addr};
   assign offset   = ioctl_addr - 25'(START);
   assign in_win   = (addr_ext >= WIN_LO) && ({1'b0, offset} < WIN_SIZE);
   assign accept   = ioctl_wr & downloading & in_win;
   // A byte that completes a word produces a write; for 16-bit words that is the odd byte.
   assign wr_hit   = accept & (~PACK | offset[0]);

   // When both ports request, the one that was not served last wins.
   assign pick_b   = b_req & (~a_req | ~rr_b);

   generate
      if (PACK) begin : g_w16
         logic [7:0] byte_lo;

         // Even bytes wait in byte_lo; the odd byte completes the word and triggers the write.
         always_ff @(posedge clk) begin
            if (rst) begin
               prom_we      <= 1'b0;
               prom_wr_addr <= '0;
               prom_data    <= '0;
               byte_lo      <= 8'h00;
            end else begin
               prom_we <= 1'b0;
               if (accept) begin
                  if (!offset[0]) begin
                     byte_lo <= ioctl_dout;
                  end else begin
                     prom_we      <= 1'b1;
                     prom_wr_addr <= offset[AW-1+SHIFT:SHIFT];
                     prom_data    <= {ioctl_dout, byte_lo};
                  end
               end
            end
         end
      end else begin : g_w8
         // Every accepted byte is a complete word and is written straight away.
         always_ff @(posedge clk) begin
            if (rst) begin
               prom_we      <= 1'b0;
               prom_wr_addr <= '0;
               prom_data    <= '0;
            end else begin
               prom_we <= 1'b0;
               if (accept) begin
                  prom_we      <= 1'b1;
                  prom_wr_addr <= offset[AW-1+SHIFT:SHIFT];
                  prom_data    <= ioctl_dout;
               end
            end
         end
      end
   endgenerate

   // done is cleared when a download starts and set when it ends, provided this memory was written.
   always_ff @(posedge clk) begin
      if (rst) begin
         dl_d  <= 1'b0;
         wrote <= 1'b0;
         done  <= 1'b0;
      end else begin
         dl_d <= downloading;
         if (downloading && !dl_d) begin
            done  <= 1'b0;
            wrote <= 1'b0;
         end
         if (!downloading && dl_d && wrote) begin
            done <= 1'b1;
         end
         if (wr_hit) begin
            wrote <= 1'b1;
         end
      end
   end

   // Read arbiter: grant, drive the read port for one cycle, capture the data, then pulse ok.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         rr_b         <= 1'b1;
         grant_b      <= 1'b0;
         prom_rd_addr <= '0;
         prom_cen     <= 1'b0;
         a_ok         <= 1'b0;
         b_ok         <= 1'b0;
         a_dout       <= '0;
         b_dout       <= '0;
      end else begin
         prom_cen <= 1'b0;
         a_ok     <= 1'b0;
         b_ok     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!downloading && (a_req || b_req)) begin
                  grant_b      <= pick_b;
                  prom_rd_addr <= pick_b ? b_addr : a_addr;
                  prom_cen     <= 1'b1;
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (grant_b) begin
                  b_dout <= prom_q;
                  b_ok   <= 1'b1;
               end else begin
                  a_dout <= prom_q;
                  a_ok   <= 1'b1;
               end
               rr_b  <= grant_b;
               state <= ST_FINISH;
            end
            ST_FINISH: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
